// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter FSM state encodings and owner index width
package arb_pkg;

   localparam int OWNER_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_GAP   = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin pick starting after last
module rr_pick4
   import arb_pkg::*;
(
   input  logic [3:0]         req,
   input  logic [OWNER_W-1:0] last,
   output logic               valid,
   output logic [OWNER_W-1:0] idx
);

   logic [OWNER_W-1:0] cand;

   // Offsets 1..4 from last; offset 4 wraps back to last itself.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= 4; i++) begin
         cand = last + i[OWNER_W-1:0];
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_grant_sched.sv
// rtl/rr_grant_sched.sv - round-robin grant scheduler with hold timeout and gap cycle
module rr_grant_sched
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_0,
   input  logic               req_1,
   input  logic               req_2,
   input  logic               req_3,
   output logic               gnt_0,
   output logic               gnt_1,
   output logic               gnt_2,
   output logic               gnt_3,
   output logic [OWNER_W-1:0] owner,
   output logic               busy,
   output logic               preempt
);

   arb_state_t         state, state_n;
   logic [3:0]         gnt_r, gnt_n;
   logic [OWNER_W-1:0] owner_r, owner_n;
   logic [OWNER_W-1:0] last_owner, last_n;
   logic [HOLD_W-1:0]  hold_cnt, hold_n;
   logic               busy_r, busy_n;
   logic               preempt_r, preempt_n;

   logic [3:0]         req_v;
   logic               pick_valid;
   logic [OWNER_W-1:0] pick_idx;
   logic               owner_req;
   logic               other_req;

   assign req_v     = {req_3, req_2, req_1, req_0};
   assign owner_req = req_v[owner_r];
   assign other_req = |(req_v & ~(4'b0001 << owner_r));

   rr_pick4 u_pick (
      .req   (req_v),
      .last  (last_owner),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         gnt_r      <= '0;
         owner_r    <= '0;
         last_owner <= 2'd3;
         hold_cnt   <= '0;
         busy_r     <= 1'b0;
         preempt_r  <= 1'b0;
      end else begin
         state      <= state_n;
         gnt_r      <= gnt_n;
         owner_r    <= owner_n;
         last_owner <= last_n;
         hold_cnt   <= hold_n;
         busy_r     <= busy_n;
         preempt_r  <= preempt_n;
      end
   end

   always_comb begin
      state_n   = ST_IDLE;
      gnt_n     = '0;
      owner_n   = owner_r;
      last_n    = last_owner;
      hold_n    = '0;
      preempt_n = 1'b0;
      case (state)
         ST_IDLE, ST_GAP: begin
            if (pick_valid) begin
               state_n = ST_GRANT;
               gnt_n   = 4'b0001 << pick_idx;
               owner_n = pick_idx;
               last_n  = pick_idx;
               hold_n  = HOLD_W'(1);
            end
         end
         ST_GRANT: begin
            if (!owner_req) begin
               state_n = ST_GAP;
            end else if (hold_cnt < HOLD_W'(MAX_HOLD)) begin
               state_n = ST_GRANT;
               gnt_n   = gnt_r;
               hold_n  = hold_cnt + HOLD_W'(1);
            end else if (other_req) begin
               state_n   = ST_GAP;
               preempt_n = 1'b1;
            end else begin
               // Nobody else waiting: keep the grant, counter saturates.
               state_n = ST_GRANT;
               gnt_n   = gnt_r;
               hold_n  = HOLD_W'(MAX_HOLD);
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      busy_n = |gnt_n;
   end

   assign gnt_0   = gnt_r[0];
   assign gnt_1   = gnt_r[1];
   assign gnt_2   = gnt_r[2];
   assign gnt_3   = gnt_r[3];
   assign owner   = owner_r;
   assign busy    = busy_r;
   assign preempt = preempt_r;

endmodule

// File: tb/tb_rr_grant_sched.sv
// tb/tb_rr_grant_sched.sv - directed self-checking bench for rr_grant_sched
module tb_rr_grant_sched;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_v = 4'b0000;
   logic       gnt_0, gnt_1, gnt_2, gnt_3;
   logic [1:0] owner;
   logic       busy, preempt;

   int errors = 0;
   int checks = 0;

   logic       mon_en = 1'b0;
   logic [3:0] mon_prev_g = 4'b0000;
   logic       mon_prev_pre = 1'b0;

   wire [3:0] gnt_v = {gnt_3, gnt_2, gnt_1, gnt_0};

   always #5 clock = ~clock;

   rr_grant_sched #(.MAX_HOLD(8), .HOLD_W(4)) dut (
      .clock   (clock),
      .reset   (reset),
      .req_0   (req_v[0]),
      .req_1   (req_v[1]),
      .req_2   (req_v[2]),
      .req_3   (req_v[3]),
      .gnt_0   (gnt_0),
      .gnt_1   (gnt_1),
      .gnt_2   (gnt_2),
      .gnt_3   (gnt_3),
      .owner   (owner),
      .busy    (busy),
      .preempt (preempt)
   );

   always @(negedge clock) begin
      if (mon_en) begin
         checks++;
         if ((gnt_v & (gnt_v - 4'd1)) !== 4'b0000) begin
            errors++;
            $display("FAIL onehot: gnt=%b required one-hot or zero", gnt_v);
         end
         checks++;
         if (busy !== (|gnt_v)) begin
            errors++;
            $display("FAIL busy_or: busy=%b required %b", busy, |gnt_v);
         end
         checks++;
         if (mon_prev_pre && preempt) begin
            errors++;
            $display("FAIL preempt_pulse: preempt=1 two cycles, required single pulse");
         end
         checks++;
         if (mon_prev_g != 4'b0000 && gnt_v != 4'b0000 && mon_prev_g != gnt_v) begin
            errors++;
            $display("FAIL owner_gap: gnt %b -> %b, required a gap cycle", mon_prev_g, gnt_v);
         end
         mon_prev_g   = gnt_v;
         mon_prev_pre = preempt;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req_v = 4'b0000;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_v = 4'b0000;
      tick();
      tick();
      mon_en = 1'b1;
      checks++;
      if ({gnt_v, busy, preempt, owner} !== 8'b0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b busy=%b preempt=%b owner=%0d required all 0",
                  gnt_v, busy, preempt, owner);
      end
      checks++;
      if (dut.hold_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold: hold_cnt=%0d required 0", dut.hold_cnt);
      end
      reset = 1'b0;
   endtask

   task automatic test_rotation();
      logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] exp_g;
      req_v = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << seq[k];
         for (int c = 0; c < 8; c++) begin
            checks++;
            if (gnt_v !== exp_g || owner !== seq[k] || preempt !== 1'b0) begin
               errors++;
               $display("FAIL rotation_grant[%0d,%0d]: gnt=%b owner=%0d preempt=%b required gnt=%b owner=%0d preempt=0",
                        k, c, gnt_v, owner, preempt, exp_g, seq[k]);
            end
            tick();
         end
         checks++;
         if (gnt_v !== 4'b0000 || preempt !== 1'b1) begin
            errors++;
            $display("FAIL rotation_gap[%0d]: gnt=%b preempt=%b required gnt=0000 preempt=1",
                     k, gnt_v, preempt);
         end
         tick();
      end
      do_reset();
   endtask

   task automatic test_saturate();
      req_v = 4'b0100;
      tick();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (gnt_v !== 4'b0100 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL saturate_grant[%0d]: gnt=%b preempt=%b required gnt=0100 preempt=0",
                     i, gnt_v, preempt);
         end
         tick();
      end
      checks++;
      if (dut.hold_cnt !== 4'd8) begin
         errors++;
         $display("FAIL saturate_hold: hold_cnt=%0d required 8", dut.hold_cnt);
      end
      req_v = 4'b0000;
      tick();
      checks++;
      if (gnt_v !== 4'b0000 || preempt !== 1'b0) begin
         errors++;
         $display("FAIL saturate_release: gnt=%b preempt=%b required gnt=0000 preempt=0",
                  gnt_v, preempt);
      end
      tick();
      do_reset();
   endtask

   task automatic test_release();
      req_v = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (gnt_v !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL release_grant1[%0d]: gnt=%b owner=%0d required gnt=0010 owner=1",
                     c, gnt_v, owner);
         end
      end
      req_v = 4'b1000;
      tick();
      checks++;
      if (gnt_v !== 4'b0000 || preempt !== 1'b0) begin
         errors++;
         $display("FAIL release_gap: gnt=%b preempt=%b required gnt=0000 preempt=0",
                  gnt_v, preempt);
      end
      req_v = 4'b1010;
      tick();
      checks++;
      if (gnt_v !== 4'b1000 || owner !== 2'd3 || preempt !== 1'b0) begin
         errors++;
         $display("FAIL release_next: gnt=%b owner=%0d preempt=%b required gnt=1000 owner=3 preempt=0",
                  gnt_v, owner, preempt);
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      req_v = 4'b0001;
      tick();
      tick();
      req_v = 4'b0000;
      tick();
      checks++;
      if (gnt_v !== 4'b0000) begin
         errors++;
         $display("FAIL same_regrant_gap: gnt=%b required 0000", gnt_v);
      end
      req_v = 4'b0001;
      tick();
      checks++;
      if (gnt_v !== 4'b0001 || owner !== 2'd0) begin
         errors++;
         $display("FAIL same_regrant: gnt=%b owner=%0d required gnt=0001 owner=0", gnt_v, owner);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      req_v = 4'b0100;
      tick();
      tick();
      tick();
      checks++;
      if (gnt_v !== 4'b0100) begin
         errors++;
         $display("FAIL midreset_pre: gnt=%b required 0100", gnt_v);
      end
      reset = 1'b1;
      req_v = 4'b0101;
      tick();
      checks++;
      if ({gnt_v, busy, preempt, owner} !== 8'b0) begin
         errors++;
         $display("FAIL midreset_clear: gnt=%b busy=%b preempt=%b owner=%0d required all 0",
                  gnt_v, busy, preempt, owner);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (gnt_v !== 4'b0001 || owner !== 2'd0) begin
         errors++;
         $display("FAIL midreset_first: gnt=%b owner=%0d required gnt=0001 owner=0", gnt_v, owner);
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_saturate();
      test_release();
      test_back_to_back();
      test_reset_mid();
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_grant_sched.md
RR_GRANT_SCHED -- requirements
Module: rr_grant_sched

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles for one owner while another requester is pending; legal range 2..15.
REQ-002 Parameter HOLD_W, default 4: width of the hold counter; SHALL satisfy 2**HOLD_W > MAX_HOLD.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Ports req_0..req_3, input, 1 each: request lines, level-sensitive, held high while access is wanted.
REQ-006 Ports gnt_0..gnt_3, output, 1 each: registered grants; at most one high in any cycle.
REQ-007 Port owner, output, 2: index of the last or current grantee; valid while busy=1.
REQ-008 Port busy, output, 1: registered; high exactly when any gnt_x is high.
REQ-009 Port preempt, output, 1: registered one-cycle pulse marking a forced release by hold timeout.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE=2'b00, GRANT=2'b01, GAP=2'b10; state 2'b11 SHALL return to IDLE on the next edge with all grants low.
REQ-011 Arbitration SHALL be round-robin: the search starts at last_owner+1 mod 4 and the first asserted req wins.
REQ-012 In IDLE or GAP with any req high in cycle t, the arbiter SHALL enter GRANT at t+1 with the winner's gnt high, owner=winner, hold_cnt=1 and last_owner=winner.
REQ-013 In IDLE or GAP with no req high, the next state SHALL be IDLE with all grants low.
REQ-014 In GRANT, if the owner's req is low in cycle t, the arbiter SHALL enter GAP at t+1 with all grants low and preempt=0.
REQ-015 In GRANT, if the owner's req is high and hold_cnt<MAX_HOLD, the arbiter SHALL stay in GRANT and increment hold_cnt.
REQ-016 In GRANT, if hold_cnt==MAX_HOLD, the owner's req is high and any other req is high, the arbiter SHALL enter GAP at t+1 with all grants low and preempt=1 for that single cycle.
REQ-017 In GRANT, if hold_cnt==MAX_HOLD and no other req is high, the arbiter SHALL keep the grant, and hold_cnt SHALL saturate at MAX_HOLD.
REQ-018 GAP SHALL last exactly one cycle, guaranteeing at least one all-low cycle between two owners, including when the same requester is re-granted.
REQ-019 Request changes in non-owner lines during GRANT SHALL not affect the grant.
REQ-020 Grant latency SHALL be exactly one cycle from the first qualifying req, and release latency exactly one cycle from req deassertion.

Reset
REQ-021 When reset is high at an edge: state=IDLE, gnt_0..gnt_3=0, busy=0, preempt=0, owner=0, hold_cnt=0 and last_owner=3, so that req_0 has first priority after reset.
REQ-022 Reset SHALL override all other behaviour, including mid-grant and during GAP; the first grant is possible at the edge after the first non-reset cycle.

Structure
REQ-023 The state encodings IDLE/GRANT/GAP and the owner-index width SHALL live in a shared package, arb_pkg, that is reused by sibling FSM blocks.
REQ-024 The round-robin pick SHALL be a combinational sub-module, rr_pick4 (inputs req[3:0] and last[1:0]; outputs valid and idx[1:0]); all other logic stays in rr_grant_sched.

Verification
REQ-025 After reset, raise req_0..req_3 together and hold them -> grants cycle 0,1,2,3,0, each lasting 8 cycles, separated by 1 gap cycle, with preempt=1 in each gap.
REQ-026 Hold only req_2 high for 20 cycles -> gnt_2 stays high for all cycles after the first grant, hold_cnt saturates at 8 and preempt stays 0.
REQ-027 Grant req_1, drop it after 3 grant cycles, keep req_1 and req_3 high -> one gap cycle, then gnt_3 is granted (round-robin past 1) and preempt=0.
REQ-028 Assert reset mid-grant on gnt_2 -> all outputs are 0 at the next edge; with req_2 and req_0 held high after release, gnt_0 is granted first.
REQ-029 Across the whole run, check continuously: gnts are one-hot or zero, busy equals the OR of the gnts, preempt is never high for two consecutive cycles, and no owner changes without a gap cycle.
